// File: rtl/uart_rx_core.sv
// UART receive engine: synchronises rx_in, detects the start bit, samples
// each bit at mid-bit with a fixed divisor, checks optional parity and the
// stop bit, and emits a one-cycle write strobe plus error flags.
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  input  logic                 fifo_full,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic          PAR_EN   = (PARITY_EN != 0);
  localparam logic          PAR_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state, state_next;
  logic                   rx_meta, rx_s, rx_s_d;
  logic [CW-1:0]          clk_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   par_flag;

  logic clk_clr, bit_clr, bit_inc, shift_en, par_sample, stop_good, stop_bad;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state and per-cycle control decode
  always_comb begin
    state_next = state;
    clk_clr    = 1'b0;
    bit_clr    = 1'b0;
    bit_inc    = 1'b0;
    shift_en   = 1'b0;
    par_sample = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      S_IDLE: begin
        // Only a high-to-low transition starts a frame, so a held-low
        // break line cannot retrigger.
        if (rx_s_d && !rx_s) begin
          state_next = S_START;
          clk_clr    = 1'b1;
        end
      end
      S_START: begin
        if (clk_cnt == HALF_M1) begin
          clk_clr    = 1'b1;
          bit_clr    = 1'b1;
          state_next = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (clk_cnt == FULL_M1) begin
          clk_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            bit_clr    = 1'b1;
            state_next = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (clk_cnt == FULL_M1) begin
          clk_clr    = 1'b1;
          par_sample = 1'b1;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (clk_cnt == FULL_M1) begin
          clk_clr    = 1'b1;
          state_next = S_IDLE;
          if (rx_s) stop_good = 1'b1;
          else      stop_bad  = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Counters, shift register and parity accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_flag  <= 1'b0;
    end else begin
      if (clk_clr || state == S_IDLE) clk_cnt <= '0;
      else                            clk_cnt <= clk_cnt + CW'(1);
      if (bit_clr)      bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + BW'(1);
      if (shift_en) shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
      if (state == S_START)  par_flag <= 1'b0;
      else if (par_sample)   par_flag <= (^shift_reg) ^ rx_s ^ PAR_ODD;
    end
  end

  // Registered outputs: strobes last exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_valid   <= stop_good;
      frame_err  <= stop_bad;
      overrun    <= stop_good & fifo_full;
      parity_err <= stop_good & PAR_EN & par_flag;
      if (stop_good) rx_data <= shift_reg;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: one instance without parity, one
// with even parity, directed corner cases plus randomized frames.
module tb_uart_rx_core;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx0 = 1'b1, rx1 = 1'b1;
  logic       ff0 = 1'b0, ff1 = 1'b0;
  logic [7:0] d0, d1;
  logic       v0, pe0, fe0, ov0, b0;
  logic       v1, pe1, fe1, ov1, b1;

  longint cyc = 0;
  int     n_assert = 0;
  int     n_fail = 0;
  int     stray = 0;

  typedef struct {
    longint     c;
    logic [7:0] d;
    logic       v, pe, fe, ov, b;
  } ev_t;
  ev_t q0[$];
  ev_t q1[$];

  uart_rx_core #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx_in(rx0), .fifo_full(ff0),
    .rx_data(d0), .rx_valid(v0), .parity_err(pe0), .frame_err(fe0),
    .overrun(ov0), .busy(b0)
  );

  uart_rx_core #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_in(rx1), .fifo_full(ff1),
    .rx_data(d1), .rx_valid(v1), .parity_err(pe1), .frame_err(fe1),
    .overrun(ov1), .busy(b1)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc is the number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe with the rising edge that will sample it
  always @(negedge clk) begin
    if (v0 || fe0) q0.push_back('{c: cyc + 1, d: d0, v: v0, pe: pe0, fe: fe0, ov: ov0, b: b0});
    if (v1 || fe1) q1.push_back('{c: cyc + 1, d: d1, v: v1, pe: pe1, fe: fe1, ov: ov1, b: b1});
    if (!v0 && (pe0 || ov0)) stray++;
    if (!v1 && (pe1 || ov1)) stray++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (at negedges) until the next rising edge is edge number s
  task automatic wait_sample(input longint s);
    while (cyc + 1 < s) @(negedge clk);
  endtask

  // Drive one frame on a line; must be called at a negedge
  task automatic send(input int line, input logic [7:0] d, input bit par,
                      input bit pbit, input bit stop);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (par) bits.push_back(pbit);
    bits.push_back(stop);
    foreach (bits[i]) begin
      if (line == 0) rx0 = bits[i];
      else           rx1 = bits[i];
      repeat (C) @(negedge clk);
    end
  endtask

  // Expected sampling edge of the strobe for a frame whose start is seen at E
  function automatic longint strobe_edge(input longint e, input int nbits);
    return e + 3 + C / 2 + nbits * C;
  endfunction

  task automatic expect_ev(input int which, input string tag, input longint e_edge,
                           input logic [7:0] d, input logic v, input logic fe,
                           input logic pe, input logic ov);
    ev_t ev;
    int  have;
    have = (which == 0) ? q0.size() : q1.size();
    chk({tag, "_present"}, longint'(have > 0), 1);
    if (have > 0) begin
      if (which == 0) ev = q0.pop_front();
      else            ev = q1.pop_front();
      chk({tag, "_edge"}, ev.c, e_edge);
      chk({tag, "_data"}, longint'(ev.d), longint'(d));
      chk({tag, "_valid"}, longint'(ev.v), longint'(v));
      chk({tag, "_frame_err"}, longint'(ev.fe), longint'(fe));
      chk({tag, "_parity_err"}, longint'(ev.pe), longint'(pe));
      chk({tag, "_overrun"}, longint'(ev.ov), longint'(ov));
      chk({tag, "_busy_after"}, longint'(ev.b), 0);
    end
  endtask

  initial begin
    longint     e;
    longint     es[3];
    logic [7:0] last_good;
    logic [7:0] bytes3[3];
    logic [7:0] rb;
    bit         pb, full;
    int         gap;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rx_data", longint'(d0), 0);
    chk("rst_rx_valid", longint'(v0), 0);
    chk("rst_parity_err", longint'(pe0), 0);
    chk("rst_frame_err", longint'(fe0), 0);
    chk("rst_overrun", longint'(ov0), 0);
    chk("rst_busy", longint'(b0), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic byte with busy-rise timing
    e = cyc + 1;
    fork
      send(0, 8'hA5, 0, 0, 1);
      begin
        wait_sample(e + 2);
        chk("basic_busy_pre", longint'(b0), 0);
        wait_sample(e + 3);
        chk("basic_busy_rise", longint'(b0), 1);
      end
    join
    expect_ev(0, "basic", strobe_edge(e, 9), 8'hA5, 1, 0, 0, 0);
    chk("basic_single", longint'(q0.size()), 0);
    last_good = 8'hA5;
    repeat (C) @(negedge clk);

    // Back-to-back with zero idle bits
    bytes3[0] = 8'h00; bytes3[1] = 8'hFF; bytes3[2] = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      es[i] = cyc + 1;
      send(0, bytes3[i], 0, 0, 1);
    end
    for (int i = 0; i < 3; i++)
      expect_ev(0, "b2b", strobe_edge(es[0], 9) + 160 * i, bytes3[i], 1, 0, 0, 0);
    last_good = 8'h3C;
    repeat (C) @(negedge clk);

    // Randomized frames with random gaps and FIFO-full state
    for (int i = 0; i < 10; i++) begin
      rb   = 8'($urandom_range(255, 0));
      full = 1'($urandom_range(1, 0));
      gap  = int'($urandom_range(20, 0));
      repeat (gap) @(negedge clk);
      ff0 = full;
      e = cyc + 1;
      send(0, rb, 0, 0, 1);
      ff0 = 1'b0;
      expect_ev(0, "rand", strobe_edge(e, 9), rb, 1, 0, 0, full);
      last_good = rb;
    end

    // Parity instance: directed then random, even parity
    e = cyc + 1;
    send(1, 8'h07, 1, 1, 1);
    expect_ev(1, "par_ok", strobe_edge(e, 10), 8'h07, 1, 0, 0, 0);
    e = cyc + 1;
    send(1, 8'h07, 1, 0, 1);
    expect_ev(1, "par_bad", strobe_edge(e, 10), 8'h07, 1, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(255, 0));
      pb = 1'($urandom_range(1, 0));
      e = cyc + 1;
      send(1, rb, 1, pb, 1);
      expect_ev(1, "par_rand", strobe_edge(e, 10), rb, 1, 0,
                1'((($countones(rb) + int'(pb)) % 2) != 0), 0);
    end

    // Short low glitch: false start, back to idle after the start sample
    repeat (C) @(negedge clk);
    e = cyc + 1;
    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    rx0 = 1'b1;
    wait_sample(e + 2 + C / 2);
    chk("glitch_busy_start", longint'(b0), 1);
    wait_sample(e + 3 + C / 2);
    chk("glitch_busy_idle", longint'(b0), 0);
    repeat (2 * C) @(negedge clk);
    chk("glitch_no_strobe", longint'(q0.size()), 0);

    // Break: line low for 30 bit times
    e = cyc + 1;
    rx0 = 1'b0;
    repeat (30 * C) @(negedge clk);
    expect_ev(0, "break", strobe_edge(e, 9), last_good, 0, 1, 0, 0);
    chk("break_no_retrigger", longint'(q0.size()), 0);
    chk("break_busy", longint'(b0), 0);
    rx0 = 1'b1;
    repeat (2 * C) @(negedge clk);
    e = cyc + 1;
    send(0, 8'h96, 0, 0, 1);
    expect_ev(0, "after_break", strobe_edge(e, 9), 8'h96, 1, 0, 0, 0);
    last_good = 8'h96;

    // Directed overrun then a clean frame
    ff0 = 1'b1;
    e = cyc + 1;
    send(0, 8'h55, 0, 0, 1);
    ff0 = 1'b0;
    expect_ev(0, "overrun", strobe_edge(e, 9), 8'h55, 1, 0, 0, 1);
    e = cyc + 1;
    send(0, 8'h5A, 0, 0, 1);
    expect_ev(0, "no_overrun", strobe_edge(e, 9), 8'h5A, 1, 0, 0, 0);
    last_good = 8'h5A;

    // Reset in the middle of data bit 4 of 0x81
    repeat (C) @(negedge clk);
    fork
      send(0, 8'h81, 0, 0, 1);
      begin
        repeat (5 * C + C / 2) @(negedge clk);
        chk("midrst_busy_before", longint'(b0), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rx_data", longint'(d0), 0);
        chk("midrst_rx_valid", longint'(v0), 0);
        chk("midrst_frame_err", longint'(fe0), 0);
        chk("midrst_busy", longint'(b0), 0);
      end
    join
    repeat (C) @(negedge clk);
    rst_n = 1'b1;
    repeat (C) @(negedge clk);
    chk("midrst_no_stale", longint'(q0.size() + q1.size()), 0);
    e = cyc + 1;
    send(0, 8'h42, 0, 0, 1);
    expect_ev(0, "after_rst", strobe_edge(e, 9), 8'h42, 1, 0, 0, 0);
    repeat (2 * C) @(negedge clk);
    chk("final_queue0", longint'(q0.size()), 0);
    chk("final_queue1", longint'(q1.size()), 0);
    chk("stray_err_flags", longint'(stray), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

UART receive engine for the UART block, the counterpart of the transmit path. It synchronises the serial `rx_in` line and detects start bits. It samples each bit at mid-bit using a fixed clock divisor, checks optional parity and the stop bit, and delivers each received byte as a one-cycle write strobe into the receive FIFO. It flags parity, framing and overrun errors alongside the data.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: `clk` cycles per bit (100 MHz / 115200). Must be even and ≥ 4.
- `DATA_BITS`, default 8: data bits per frame, 5–8, LSB first.
- `PARITY_EN`, default 0: 1 means one parity bit follows the data.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity. Ignored when `PARITY_EN`=0.

Ports:
- `clk`, input, 1: single clock for all logic.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rx_in`, input, 1: serial line, idle high, asynchronous to `clk`.
- `fifo_full`, input, 1: full flag of the receive FIFO.
- `rx_data`, output, `DATA_BITS`: last received byte; drives the receive FIFO data input.
- `rx_valid`, output, 1: one-cycle strobe for a good stop bit; drives the FIFO write enable.
- `parity_err`, output, 1: valid only while `rx_valid`=1; set when the received parity is wrong.
- `frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `overrun`, output, 1: one-cycle pulse when `rx_valid`=1 and `fifo_full`=1.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- **Synchronisation.** `rx_in` passes through a 2-flop synchroniser, giving `rx_s`. `rx_s_d` is a registered copy of `rx_s`. Both synchroniser flops reset to 1.
- **States.** IDLE, START, DATA, PARITY, STOP. `clk_cnt` is a counter of width clog2(`CLKS_PER_BIT`). `bit_cnt` is a counter of width clog2(`DATA_BITS`).
- **IDLE.** A falling edge (`rx_s_d`=1 and `rx_s`=0) moves the block to START with `clk_cnt`=0. A line that is held low (break) does not retrigger.
- **START.** When `clk_cnt` = `CLKS_PER_BIT`/2−1, sample `rx_s`:
  - 0: go to DATA with `clk_cnt`=0 and `bit_cnt`=0.
  - 1: false start; return to IDLE with no outputs asserted.
- **DATA.** When `clk_cnt` = `CLKS_PER_BIT`−1, shift `rx_s` into the shift register MSB-first, so the first received bit ends up at bit 0.
  - After `DATA_BITS` samples, go to PARITY if `PARITY_EN`=1, otherwise to STOP.
- **PARITY.** Sample at `CLKS_PER_BIT`−1. The error flag is XOR of the data bits, the parity bit and `PARITY_ODD`. Then go to STOP.
- **STOP.** Sample at `CLKS_PER_BIT`−1, which is mid stop bit, then return to IDLE.
  - `rx_s`=1: load `rx_data`, pulse `rx_valid`, and drive `parity_err` with the flag (0 when parity is disabled).
  - `rx_s`=0: pulse `frame_err`. `rx_valid` stays 0 and `rx_data` is unchanged.
- **Overrun.** `overrun` = `rx_valid` & `fifo_full`, registered to the same cycle as `rx_valid`. `rx_valid` is still asserted; the FIFO drops the write.
- **Counters.** Both counters wrap to 0 on every bit transition. No arithmetic wider than the counter widths is needed.
- **Reset mid-frame.** Reset returns the block to IDLE. The partial frame is discarded and no strobe is generated.

## Timing
- **Reset values.**
  - `rx_data` = 0.
  - `rx_valid`, `parity_err`, `frame_err`, `overrun`, `busy` = 0.
  - Synchroniser flops = 1.
- **Latency.** Let E be the first edge where `rx_in`=0 is sampled. Let N = `DATA_BITS` + `PARITY_EN` + 1 and C = `CLKS_PER_BIT`.
  - `busy` rises at E+3.
  - `rx_valid` (or `frame_err`) asserts at E+3+C/2+N·C for exactly 1 cycle.
- **Frame gap.** After the STOP sample, the block is in IDLE on the next cycle. A start edge arriving C/2 later, at the nominal end of the stop bit, is accepted.
- **Output hold.** `rx_data` holds its value until the next good frame.
- **Error pulses.** `parity_err` and `overrun` are meaningful only in the `rx_valid` cycle and are 0 otherwise.
- **Handshake.** There is no backpressure; the receiver never stalls.

## Test plan
Default parameters for the bench: `CLKS_PER_BIT`=16, `DATA_BITS`=8.
- **Basic byte.** Frame 0xA5, no parity → exactly one `rx_valid` pulse at E+3+8+9·16 = E+155 with `rx_data`=0xA5; all error flags 0; `busy` low the next cycle.
- **Back-to-back.** Frames 0x00, 0xFF, 0x3C sent with zero idle bits → three `rx_valid` pulses spaced 160 cycles apart with the correct bytes; no `frame_err`.
- **Parity.** `PARITY_EN`=1, `PARITY_ODD`=0:
  - 0x07 with parity bit 1 → `rx_valid`=1, `parity_err`=0.
  - Same byte with parity bit 0 → `rx_valid`=1, `parity_err`=1.
- **Glitch and break.**
  - Low glitch of 4 cycles on the idle line → return to IDLE after the START sample; no strobes.
  - Line held low for 30 bit times → one `frame_err` pulse, `rx_data` unchanged, no retrigger until the line goes high then low again.
- **Overrun.** `fifo_full`=1 during the reception of 0x55 → `rx_valid`=1 and `overrun`=1 in the same cycle; `overrun`=0 on the next frame with `fifo_full`=0.
- **Reset mid-frame.** Assert `rst_n` low during bit 4 of 0x81 → all outputs 0 immediately. After release, a clean 0x42 frame is received correctly and no stale strobe appears.
